// File: rtl/arena_pkg.sv
// Shared encodings and the power-on arena layout for the BombMan arena controller.
package arena_pkg;

  typedef enum logic [1:0] {
    CELL_BLANK = 2'b00,
    CELL_BLOCK = 2'b01,
    CELL_PA    = 2'b10,
    CELL_PB    = 2'b11
  } cell_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    GS_PLAY   = 2'd0,
    GS_A_WINS = 2'd1,
    GS_B_WINS = 2'd2,
    GS_DRAW   = 2'd3
  } gstate_e;

  localparam logic [6:0] INIT_POS_A = 7'd11;
  localparam logic [6:0] INIT_POS_B = 7'd88;

  // Border ring plus the fixed interior obstacles.
  function automatic logic [99:0] block_mask();
    logic [99:0] m;
    m = '0;
    for (int i = 0; i < 100; i++) begin
      if (i < 10 || i >= 90 || (i % 10) == 0 || (i % 10) == 9) m[i] = 1'b1;
    end
    m[13] = 1'b1; m[17] = 1'b1; m[24] = 1'b1; m[32] = 1'b1; m[34] = 1'b1;
    m[38] = 1'b1; m[46] = 1'b1; m[51] = 1'b1; m[56] = 1'b1; m[57] = 1'b1;
    m[62] = 1'b1; m[63] = 1'b1; m[76] = 1'b1; m[84] = 1'b1;
    return m;
  endfunction

  localparam logic [99:0] INIT_ARENA_0 = block_mask() | (100'd1 << INIT_POS_B);
  localparam logic [99:0] INIT_ARENA_1 = (100'd1 << INIT_POS_A) | (100'd1 << INIT_POS_B);

endpackage

// File: rtl/arena_move_check.sv
// Combinational move geometry: target cell for pos+dir and whether it stays on the grid.
module arena_move_check
  import arena_pkg::*;
(
  input  logic [6:0] i_pos,
  input  logic [1:0] i_dir,
  output logic [6:0] o_target,
  output logic       o_inside
);

  logic [3:0] w_col;
  assign w_col = 4'(i_pos % 7'd10);

  always_comb begin
    o_target = i_pos;
    o_inside = 1'b0;
    case (dir_e'(i_dir))
      DIR_UP: begin
        o_target = i_pos - 7'd10;
        o_inside = (i_pos >= 7'd10);
      end
      DIR_DOWN: begin
        o_target = i_pos + 7'd10;
        o_inside = (i_pos < 7'd90);
      end
      // Horizontal moves must not wrap into the neighbouring row.
      DIR_LEFT: begin
        o_target = i_pos - 7'd1;
        o_inside = (w_col != 4'd0);
      end
      DIR_RIGHT: begin
        o_target = i_pos + 7'd1;
        o_inside = (w_col != 4'd9);
      end
    endcase
  end

endmodule

// File: rtl/arena_ctrl.sv
// Game-tick controller: owns arena/bomb planes, ages bombs, resolves blasts,
// applies damage, services player requests and decides the winner.
module arena_ctrl
  import arena_pkg::*;
#(
  parameter int unsigned FUSE        = 3,
  parameter int unsigned HEALTH_INIT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restart,
  input  logic         tick,
  input  logic         req_a,
  input  logic [1:0]   dir_a,
  input  logic         bomb_a,
  input  logic         req_b,
  input  logic [1:0]   dir_b,
  input  logic         bomb_b,
  output logic [99:0]  arena_0,
  output logic [99:0]  arena_1,
  output logic [99:0]  bombs_0,
  output logic [99:0]  bombs_1,
  output logic [1:0]   healthA,
  output logic [1:0]   healthB,
  output logic [1:0]   game_state,
  output logic         busy,
  output logic         overrun
);

  localparam logic [1:0] FuseCode   = 2'(FUSE);
  localparam logic [1:0] HealthInit = 2'(HEALTH_INIT);

  typedef enum logic [2:0] {StIdle, StScan, StDamage, StAct0, StAct1, StEnd} state_e;

  state_e      r_state;
  logic [6:0]  r_idx;
  logic [3:0]  r_col;
  logic [99:0] r_blast;
  logic [99:0] r_arena0, r_arena1, r_bombs0, r_bombs1;
  logic [6:0]  r_pos_a, r_pos_b, r_bpos_a, r_bpos_b;
  logic [1:0]  r_health_a, r_health_b, r_game_state;
  logic [1:0]  r_dir_a, r_dir_b;
  logic        r_busy, r_overrun, r_first;
  logic        r_pend_a, r_pend_b, r_drop_a, r_drop_b, r_live_a, r_live_b;

  // r_first == 0 means A acts first in ACT0.
  logic       w_serve_b, w_pend, w_drop, w_live, w_inside, w_move_ok, w_drop_ok;
  logic [6:0] w_pos, w_target, w_tidx;
  logic [1:0] w_dir, w_pcode, w_scan_code;

  assign w_serve_b   = (r_state == StAct0) ? r_first : ~r_first;
  assign w_pos       = w_serve_b ? r_pos_b  : r_pos_a;
  assign w_dir       = w_serve_b ? r_dir_b  : r_dir_a;
  assign w_pend      = w_serve_b ? r_pend_b : r_pend_a;
  assign w_drop      = w_serve_b ? r_drop_b : r_drop_a;
  assign w_live      = w_serve_b ? r_live_b : r_live_a;
  assign w_pcode     = w_serve_b ? CELL_PB  : CELL_PA;
  assign w_scan_code = {r_bombs1[r_idx], r_bombs0[r_idx]};

  arena_move_check u_move_check (
    .i_pos    (w_pos),
    .i_dir    (w_dir),
    .o_target (w_target),
    .o_inside (w_inside)
  );

  assign w_tidx    = w_inside ? w_target : w_pos;
  assign w_move_ok = w_inside && ({r_arena1[w_tidx], r_arena0[w_tidx]} == CELL_BLANK) &&
                     ({r_bombs1[w_tidx], r_bombs0[w_tidx]} == 2'b00);
  assign w_drop_ok = !w_live && ({r_bombs1[w_pos], r_bombs0[w_pos]} == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_col        <= '0;
      r_blast      <= '0;
      r_arena0     <= INIT_ARENA_0;
      r_arena1     <= INIT_ARENA_1;
      r_bombs0     <= '0;
      r_bombs1     <= '0;
      r_pos_a      <= INIT_POS_A;
      r_pos_b      <= INIT_POS_B;
      r_bpos_a     <= '0;
      r_bpos_b     <= '0;
      r_health_a   <= HealthInit;
      r_health_b   <= HealthInit;
      r_game_state <= GS_PLAY;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_first      <= 1'b0;
      r_pend_a     <= 1'b0;
      r_pend_b     <= 1'b0;
      r_dir_a      <= '0;
      r_dir_b      <= '0;
      r_drop_a     <= 1'b0;
      r_drop_b     <= 1'b0;
      r_live_a     <= 1'b0;
      r_live_b     <= 1'b0;
    end else if (r_state == StIdle && restart) begin
      r_idx        <= '0;
      r_col        <= '0;
      r_blast      <= '0;
      r_arena0     <= INIT_ARENA_0;
      r_arena1     <= INIT_ARENA_1;
      r_bombs0     <= '0;
      r_bombs1     <= '0;
      r_pos_a      <= INIT_POS_A;
      r_pos_b      <= INIT_POS_B;
      r_bpos_a     <= '0;
      r_bpos_b     <= '0;
      r_health_a   <= HealthInit;
      r_health_b   <= HealthInit;
      r_game_state <= GS_PLAY;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_first      <= 1'b0;
      r_pend_a     <= 1'b0;
      r_pend_b     <= 1'b0;
      r_dir_a      <= '0;
      r_dir_b      <= '0;
      r_drop_a     <= 1'b0;
      r_drop_b     <= 1'b0;
      r_live_a     <= 1'b0;
      r_live_b     <= 1'b0;
    end else begin
      if (tick && r_busy) r_overrun <= 1'b1;
      case (r_state)
        StIdle: begin
          if (tick && r_game_state == GS_PLAY) begin
            r_state <= StScan;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_col   <= '0;
          end
        end
        StScan: begin
          if (w_scan_code == 2'b01) begin
            {r_bombs1[r_idx], r_bombs0[r_idx]} <= 2'b00;
            r_blast[r_idx] <= 1'b1;
            if (r_col != 4'd0)     r_blast[r_idx - 7'd1]  <= 1'b1;
            if (r_col != 4'd9)     r_blast[r_idx + 7'd1]  <= 1'b1;
            if (r_idx >= 7'd10)    r_blast[r_idx - 7'd10] <= 1'b1;
            if (r_idx <  7'd90)    r_blast[r_idx + 7'd10] <= 1'b1;
            if (r_live_a && r_bpos_a == r_idx) r_live_a <= 1'b0;
            if (r_live_b && r_bpos_b == r_idx) r_live_b <= 1'b0;
          end else if (w_scan_code != 2'b00) begin
            {r_bombs1[r_idx], r_bombs0[r_idx]} <= w_scan_code - 2'd1;
          end
          if (r_idx == 7'd99) begin
            r_state <= StDamage;
          end else begin
            r_idx <= r_idx + 7'd1;
            r_col <= (r_col == 4'd9) ? 4'd0 : r_col + 4'd1;
          end
        end
        StDamage: begin
          if (r_blast[r_pos_a] && r_health_a != 2'd0) r_health_a <= r_health_a - 2'd1;
          if (r_blast[r_pos_b] && r_health_b != 2'd0) r_health_b <= r_health_b - 2'd1;
          r_blast <= '0;
          r_state <= StAct0;
        end
        StAct0, StAct1: begin
          if (w_pend && w_drop && w_drop_ok) begin
            {r_bombs1[w_pos], r_bombs0[w_pos]} <= FuseCode;
            if (w_serve_b) begin
              r_live_b <= 1'b1;
              r_bpos_b <= w_pos;
            end else begin
              r_live_a <= 1'b1;
              r_bpos_a <= w_pos;
            end
          end else if (w_pend && !w_drop && w_move_ok) begin
            {r_arena1[w_pos], r_arena0[w_pos]}   <= CELL_BLANK;
            {r_arena1[w_tidx], r_arena0[w_tidx]} <= w_pcode;
            if (w_serve_b) r_pos_b <= w_tidx;
            else           r_pos_a <= w_tidx;
          end
          if (w_serve_b) r_pend_b <= 1'b0;
          else           r_pend_a <= 1'b0;
          r_state <= (r_state == StAct0) ? StAct1 : StEnd;
        end
        StEnd: begin
          if (r_health_a == 2'd0 && r_health_b == 2'd0) r_game_state <= GS_DRAW;
          else if (r_health_a == 2'd0)                  r_game_state <= GS_B_WINS;
          else if (r_health_b == 2'd0)                  r_game_state <= GS_A_WINS;
          r_first <= ~r_first;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
      // A fresh request arriving in the servicing cycle survives for the next tick.
      if (req_a) begin
        r_pend_a <= 1'b1;
        r_dir_a  <= dir_a;
        r_drop_a <= bomb_a;
      end
      if (req_b) begin
        r_pend_b <= 1'b1;
        r_dir_b  <= dir_b;
        r_drop_b <= bomb_b;
      end
    end
  end

  assign arena_0    = r_arena0;
  assign arena_1    = r_arena1;
  assign bombs_0    = r_bombs0;
  assign bombs_1    = r_bombs1;
  assign healthA    = r_health_a;
  assign healthB    = r_health_b;
  assign game_state = r_game_state;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule
